// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding, port ids and default timeout.
package bus_arbiter_pkg;

  localparam int BUS_TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INST_BUSY = 2'd1,
    ST_DATA_BUSY = 2'd2
  } bus_state_e;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } bus_port_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Wait-cycle counter for a memory transaction; saturates at LIMIT.
module bus_timeout_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over count; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                    cnt_d = '0;
    else if (enable_i && cnt_q != LIM) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIM);

endmodule

// File: rtl/bus_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one single-port memory with timeout abort.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        inst_request_i,
  input  logic [31:0] inst_address_i,
  output logic [31:0] inst_data_o,
  output logic        inst_ready_o,
  input  logic        data_request_i,
  input  logic        data_write_i,
  input  logic [3:0]  data_select_i,
  input  logic [31:0] data_address_i,
  input  logic [31:0] data_write_data_i,
  output logic [31:0] data_read_data_o,
  output logic        data_ready_o,
  output logic        mem_request_o,
  output logic        mem_write_o,
  output logic [3:0]  mem_select_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_write_data_o,
  input  logic [31:0] mem_read_data_i,
  input  logic        mem_ready_i,
  output logic        stall_request_o,
  output logic        bus_error_o
);

  bus_state_e  state_q, state_d;
  bus_port_e   last_q, last_d;

  logic        inst_ready_q, inst_ready_d, data_ready_q, data_ready_d;
  logic [31:0] inst_data_q, inst_data_d, data_rdata_q, data_rdata_d;
  logic        bus_error_q, bus_error_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [3:0]  mem_sel_q, mem_sel_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  logic req_inst, req_data, grant_inst, grant_data;
  logic busy, done_ok, abort, finish, expired;
  logic [31:0] rdata;

  // A port whose ready pulse is showing is still holding its request; mask it.
  assign req_inst   = inst_request_i & ~inst_ready_q;
  assign req_data   = data_request_i & ~data_ready_q;
  assign grant_data = (state_q == ST_IDLE) & req_data & (~req_inst | (last_q == PORT_INST));
  assign grant_inst = (state_q == ST_IDLE) & req_inst & ~grant_data;
  assign busy       = (state_q != ST_IDLE);
  assign done_ok    = busy & mem_ready_i;
  assign abort      = busy & ~mem_ready_i & expired;
  assign finish     = done_ok | abort;

  bus_timeout_counter #(.LIMIT(TIMEOUT)) u_tmo (
    .clk_i    (clock_i),
    .rst_ni   (reset_ni),
    .clear_i  (grant_inst | grant_data),
    .enable_i (busy & ~mem_ready_i),
    .expired_o(expired)
  );

  // State and last-granted registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      last_q  <= PORT_INST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state: grant from IDLE, return to IDLE on completion or abort.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d = ST_DATA_BUSY;
          last_d  = PORT_DATA;
        end else if (grant_inst) begin
          state_d = ST_INST_BUSY;
          last_d  = PORT_INST;
        end
      end
      ST_INST_BUSY, ST_DATA_BUSY: if (finish) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values: latch command on grant, one-cycle ready/data on finish.
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_sel_d    = mem_sel_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    inst_data_d  = '0;
    data_rdata_d = '0;
    bus_error_d  = 1'b0;
    rdata        = (done_ok && !mem_we_q) ? mem_read_data_i : 32'h0;
    if (grant_data) begin
      mem_req_d   = 1'b1;
      mem_we_d    = data_write_i;
      mem_sel_d   = data_select_i;
      mem_addr_d  = data_address_i;
      mem_wdata_d = data_write_data_i;
    end else if (grant_inst) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_sel_d   = 4'hF;
      mem_addr_d  = inst_address_i;
      mem_wdata_d = '0;
    end
    if (finish) begin
      mem_req_d   = 1'b0;
      bus_error_d = abort;
      if (state_q == ST_DATA_BUSY) begin
        data_ready_d = 1'b1;
        data_rdata_d = rdata;
      end else begin
        inst_ready_d = 1'b1;
        inst_data_d  = rdata;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      inst_data_q  <= '0;
      data_rdata_q <= '0;
      bus_error_q  <= 1'b0;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
      inst_data_q  <= inst_data_d;
      data_rdata_q <= data_rdata_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign inst_ready_o     = inst_ready_q;
  assign inst_data_o      = inst_data_q;
  assign data_ready_o     = data_ready_q;
  assign data_read_data_o = data_rdata_q;
  assign bus_error_o      = bus_error_q;
  assign mem_request_o    = mem_req_q;
  assign mem_write_o      = mem_we_q;
  assign mem_select_o     = mem_sel_q;
  assign mem_address_o    = mem_addr_q;
  assign mem_write_data_o = mem_wdata_q;
  assign stall_request_o  = (inst_request_i & ~inst_ready_q) | (data_request_i & ~data_ready_q);

endmodule
